// File: rtl/TileLinkUL_pkg.sv
// TL-UL channel structs and opcode encodings shared by hosts, devices and buffers.
// Widths follow a 32-bit data bus with 8-bit source IDs.
package TileLinkUL_pkg;

   localparam int TL_AW  = 32;
   localparam int TL_DW  = 32;
   localparam int TL_AIW = 8;
   localparam int TL_DIW = 1;
   localparam int TL_SZW = 2;
   localparam int TL_DBW = TL_DW / 8;

   localparam logic [2:0] PutFullData    = 3'h0;
   localparam logic [2:0] PutPartialData = 3'h1;
   localparam logic [2:0] Get            = 3'h4;
   localparam logic [2:0] AccessAck      = 3'h0;
   localparam logic [2:0] AccessAckData  = 3'h1;

   typedef struct packed {
      logic              a_valid;
      logic [2:0]        a_opcode;
      logic [2:0]        a_param;
      logic [TL_SZW-1:0] a_size;
      logic [TL_AIW-1:0] a_source;
      logic [TL_AW-1:0]  a_address;
      logic [TL_DBW-1:0] a_mask;
      logic [TL_DW-1:0]  a_data;
      logic              d_ready;
   } tl_m2s_t;

   typedef struct packed {
      logic              d_valid;
      logic [2:0]        d_opcode;
      logic [2:0]        d_param;
      logic [TL_SZW-1:0] d_size;
      logic [TL_AIW-1:0] d_source;
      logic [TL_DIW-1:0] d_sink;
      logic [TL_DW-1:0]  d_data;
      logic              d_error;
      logic              a_ready;
   } tl_s2m_t;

   // Buffered beat contents: everything except the handshake bits.
   typedef struct packed {
      logic [2:0]        a_opcode;
      logic [2:0]        a_param;
      logic [TL_SZW-1:0] a_size;
      logic [TL_AIW-1:0] a_source;
      logic [TL_AW-1:0]  a_address;
      logic [TL_DBW-1:0] a_mask;
      logic [TL_DW-1:0]  a_data;
   } tl_a_pl_t;

   typedef struct packed {
      logic [2:0]        d_opcode;
      logic [2:0]        d_param;
      logic [TL_SZW-1:0] d_size;
      logic [TL_AIW-1:0] d_source;
      logic [TL_DIW-1:0] d_sink;
      logic [TL_DW-1:0]  d_data;
      logic              d_error;
   } tl_d_pl_t;

endpackage

// File: rtl/tlul_fifo_sync.sv
// TL-UL channel buffer: independent first-word-fall-through FIFOs on A and D,
// an in-flight request limit, occupancy reporting and a sticky spurious-response flag.
module tlul_fifo_sync
   import TileLinkUL_pkg::*;
#(
   parameter int ReqDepth       = 2,
   parameter int RspDepth       = 2,
   parameter int MaxOutstanding = 4,
   localparam int ReqLvlW = (ReqDepth > 0) ? $clog2(ReqDepth + 1) : 1,
   localparam int RspLvlW = (RspDepth > 0) ? $clog2(RspDepth + 1) : 1,
   localparam int OutW    = $clog2(MaxOutstanding + 1)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  tl_m2s_t            tl_h_i,
   output tl_s2m_t            tl_h_o,
   output tl_m2s_t            tl_d_o,
   input  tl_s2m_t            tl_d_i,
   output logic [ReqLvlW-1:0] req_level_o,
   output logic [RspLvlW-1:0] rsp_level_o,
   output logic [OutW-1:0]    outstanding_o,
   output logic               err_o
);

   // Handshake: a beat transfers on a rising edge where valid && ready; valid never
   // waits on ready, and a buffered channel's ready depends only on its own fill state.
   logic            w_below_max;
   logic            w_h_a_ready;
   logic            w_h_a_acc;
   logic            w_d_a_valid;
   logic            w_h_d_valid;
   logic            w_h_d_acc;
   logic            w_d_d_ready;
   tl_a_pl_t        w_a_in;
   tl_a_pl_t        w_a_out;
   tl_d_pl_t        w_d_in;
   tl_d_pl_t        w_d_out;
   logic [OutW-1:0] r_outstanding;
   logic            r_err;

   assign w_below_max = (r_outstanding < OutW'(MaxOutstanding));
   assign w_h_a_acc   = tl_h_i.a_valid && w_h_a_ready;
   assign w_h_d_acc   = w_h_d_valid && tl_h_i.d_ready;

   always_comb begin
      w_a_in           = '0;
      w_a_in.a_opcode  = tl_h_i.a_opcode;
      w_a_in.a_param   = tl_h_i.a_param;
      w_a_in.a_size    = tl_h_i.a_size;
      w_a_in.a_source  = tl_h_i.a_source;
      w_a_in.a_address = tl_h_i.a_address;
      w_a_in.a_mask    = tl_h_i.a_mask;
      w_a_in.a_data    = tl_h_i.a_data;
   end

   always_comb begin
      w_d_in          = '0;
      w_d_in.d_opcode = tl_d_i.d_opcode;
      w_d_in.d_param  = tl_d_i.d_param;
      w_d_in.d_size   = tl_d_i.d_size;
      w_d_in.d_source = tl_d_i.d_source;
      w_d_in.d_sink   = tl_d_i.d_sink;
      w_d_in.d_data   = tl_d_i.d_data;
      w_d_in.d_error  = tl_d_i.d_error;
   end

   // ---------------- A channel ----------------
   if (ReqDepth > 0) begin : g_req_fifo
      localparam int PtrW = (ReqDepth > 1) ? $clog2(ReqDepth) : 1;
      tl_a_pl_t           r_mem [ReqDepth];
      logic [PtrW-1:0]    r_wptr;
      logic [PtrW-1:0]    r_rptr;
      logic [ReqLvlW-1:0] r_level;
      logic               w_full;
      logic               w_empty;
      logic               w_push;
      logic               w_pop;

      assign w_full      = (r_level == ReqLvlW'(ReqDepth));
      assign w_empty     = (r_level == '0);
      // No pop-while-full bypass keeps host a_ready off the device a_ready path.
      assign w_h_a_ready = !w_full && w_below_max;
      assign w_push      = tl_h_i.a_valid && w_h_a_ready;
      assign w_pop       = tl_d_i.a_ready && !w_empty;
      assign w_d_a_valid = !w_empty;
      assign w_a_out     = r_mem[r_rptr];
      assign req_level_o = r_level;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int i = 0; i < ReqDepth; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
         end else begin
            if (w_push) begin
               r_mem[r_wptr] <= w_a_in;
               r_wptr        <= (r_wptr == PtrW'(ReqDepth - 1)) ? '0 : r_wptr + PtrW'(1);
            end
            if (w_pop) begin
               r_rptr <= (r_rptr == PtrW'(ReqDepth - 1)) ? '0 : r_rptr + PtrW'(1);
            end
            if (w_push && !w_pop) begin
               r_level <= r_level + ReqLvlW'(1);
            end else if (!w_push && w_pop) begin
               r_level <= r_level - ReqLvlW'(1);
            end
         end
      end
   end else begin : g_req_pass
      assign w_a_out     = w_a_in;
      assign w_h_a_ready = tl_d_i.a_ready && w_below_max;
      assign w_d_a_valid = tl_h_i.a_valid && w_below_max;
      assign req_level_o = '0;
   end

   // ---------------- D channel ----------------
   if (RspDepth > 0) begin : g_rsp_fifo
      localparam int PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
      tl_d_pl_t           r_mem [RspDepth];
      logic [PtrW-1:0]    r_wptr;
      logic [PtrW-1:0]    r_rptr;
      logic [RspLvlW-1:0] r_level;
      logic               w_full;
      logic               w_empty;
      logic               w_push;
      logic               w_pop;

      assign w_full      = (r_level == RspLvlW'(RspDepth));
      assign w_empty     = (r_level == '0);
      assign w_d_d_ready = !w_full;
      assign w_push      = tl_d_i.d_valid && !w_full;
      assign w_pop       = tl_h_i.d_ready && !w_empty;
      assign w_h_d_valid = !w_empty;
      assign w_d_out     = r_mem[r_rptr];
      assign rsp_level_o = r_level;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int i = 0; i < RspDepth; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
         end else begin
            if (w_push) begin
               r_mem[r_wptr] <= w_d_in;
               r_wptr        <= (r_wptr == PtrW'(RspDepth - 1)) ? '0 : r_wptr + PtrW'(1);
            end
            if (w_pop) begin
               r_rptr <= (r_rptr == PtrW'(RspDepth - 1)) ? '0 : r_rptr + PtrW'(1);
            end
            if (w_push && !w_pop) begin
               r_level <= r_level + RspLvlW'(1);
            end else if (!w_push && w_pop) begin
               r_level <= r_level - RspLvlW'(1);
            end
         end
      end
   end else begin : g_rsp_pass
      assign w_d_out     = w_d_in;
      assign w_d_d_ready = tl_h_i.d_ready;
      assign w_h_d_valid = tl_d_i.d_valid;
      assign rsp_level_o = '0;
   end

   // ---------------- In-flight tracking ----------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_outstanding <= '0;
         r_err         <= 1'b0;
      end else begin
         // A response with nothing in flight is spurious; the count stays pinned at zero.
         if (w_h_d_acc && (r_outstanding == '0)) begin
            r_err <= 1'b1;
         end
         case ({w_h_a_acc, w_h_d_acc})
            2'b10:   r_outstanding <= r_outstanding + OutW'(1);
            2'b01: begin
               if (r_outstanding != '0) r_outstanding <= r_outstanding - OutW'(1);
            end
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   assign outstanding_o = r_outstanding;
   assign err_o         = r_err;

   always_comb begin
      tl_d_o           = '0;
      tl_d_o.a_valid   = w_d_a_valid;
      tl_d_o.a_opcode  = w_a_out.a_opcode;
      tl_d_o.a_param   = w_a_out.a_param;
      tl_d_o.a_size    = w_a_out.a_size;
      tl_d_o.a_source  = w_a_out.a_source;
      tl_d_o.a_address = w_a_out.a_address;
      tl_d_o.a_mask    = w_a_out.a_mask;
      tl_d_o.a_data    = w_a_out.a_data;
      tl_d_o.d_ready   = w_d_d_ready;
   end

   always_comb begin
      tl_h_o          = '0;
      tl_h_o.d_valid  = w_h_d_valid;
      tl_h_o.d_opcode = w_d_out.d_opcode;
      tl_h_o.d_param  = w_d_out.d_param;
      tl_h_o.d_size   = w_d_out.d_size;
      tl_h_o.d_source = w_d_out.d_source;
      tl_h_o.d_sink   = w_d_out.d_sink;
      tl_h_o.d_data   = w_d_out.d_data;
      tl_h_o.d_error  = w_d_out.d_error;
      tl_h_o.a_ready  = w_h_a_ready;
   end

endmodule

// File: tb/tb_tlul_fifo_sync.sv
// Bench for tlul_fifo_sync: a buffered instance (depths 2/2) driven by directed sequences
// and a pass-through instance (depths 0/0) driven from a vector table.
module tb_tlul_fifo_sync;
   import TileLinkUL_pkg::*;

   logic    clk = 1'b0;
   logic    rst_n = 1'b0;
   always #5 clk = ~clk;

   tl_m2s_t h_i, d_o, h0_i, d0_o;
   tl_s2m_t h_o, d_i, h0_o, d0_i;
   logic [1:0] req_lvl, rsp_lvl;
   logic [0:0] req_lvl0, rsp_lvl0;
   logic [2:0] outst, outst0;
   logic       err, err0;

   tlul_fifo_sync #(.ReqDepth(2), .RspDepth(2), .MaxOutstanding(4)) dut (
      .clk_i(clk), .rst_ni(rst_n), .tl_h_i(h_i), .tl_h_o(h_o), .tl_d_o(d_o), .tl_d_i(d_i),
      .req_level_o(req_lvl), .rsp_level_o(rsp_lvl), .outstanding_o(outst), .err_o(err));

   tlul_fifo_sync #(.ReqDepth(0), .RspDepth(0), .MaxOutstanding(4)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .tl_h_i(h0_i), .tl_h_o(h0_o), .tl_d_o(d0_o), .tl_d_i(d0_i),
      .req_level_o(req_lvl0), .rsp_level_o(rsp_lvl0), .outstanding_o(outst0), .err_o(err0));

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] obs_q[$];

   // Device-side A beats of the buffered instance, in the order they were taken.
   always @(negedge clk) begin
      if (rst_n && d_o.a_valid && d_i.a_ready) obs_q.push_back(d_o.a_address);
   end

   typedef struct {
      logic hav, dar, hdr, ddv;
      logic exp_ar, exp_av, exp_dv, exp_dr;
      int   exp_out;
   } vec_t;
   vec_t vecs [14];

   function automatic vec_t mk(input logic [3:0] in_bits, input logic [3:0] ex_bits, input int o);
      vec_t v;
      v.hav = in_bits[3]; v.dar = in_bits[2]; v.hdr = in_bits[1]; v.ddv = in_bits[0];
      v.exp_ar = ex_bits[3]; v.exp_av = ex_bits[2]; v.exp_dv = ex_bits[1]; v.exp_dr = ex_bits[0];
      v.exp_out = o;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drive_a(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input logic [7:0] src);
      h_i.a_valid   = 1'b1;
      h_i.a_opcode  = op;
      h_i.a_param   = 3'h0;
      h_i.a_size    = 2'd2;
      h_i.a_source  = src;
      h_i.a_address = addr;
      h_i.a_mask    = 4'hF;
      h_i.a_data    = data;
   endtask

   task automatic drive_d(input logic [2:0] op, input logic [31:0] data, input logic [7:0] src);
      d_i.d_valid  = 1'b1;
      d_i.d_opcode = op;
      d_i.d_param  = 3'h0;
      d_i.d_size   = 2'd2;
      d_i.d_source = src;
      d_i.d_sink   = 1'b0;
      d_i.d_data   = data;
      d_i.d_error  = 1'b0;
   endtask

   task automatic reset_dut();
      h_i   = '0;
      d_i   = '0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      settle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      h_i = '0; d_i = '0; h0_i = '0; d0_i = '0;
      vecs[0]  = mk(4'b1000, 4'b0100, 0);
      vecs[1]  = mk(4'b1100, 4'b1100, 0);
      vecs[2]  = mk(4'b0100, 4'b1000, 1);
      vecs[3]  = mk(4'b1100, 4'b1100, 1);
      vecs[4]  = mk(4'b1100, 4'b1100, 2);
      vecs[5]  = mk(4'b1100, 4'b1100, 3);
      vecs[6]  = mk(4'b1100, 4'b0000, 4);
      vecs[7]  = mk(4'b1000, 4'b0000, 4);
      vecs[8]  = mk(4'b0101, 4'b0010, 4);
      vecs[9]  = mk(4'b1111, 4'b0011, 4);
      vecs[10] = mk(4'b1110, 4'b1101, 3);
      vecs[11] = mk(4'b1111, 4'b0011, 4);
      vecs[12] = mk(4'b1111, 4'b1111, 3);
      vecs[13] = mk(4'b0000, 4'b0000, 3);

      // Reset state
      #2;
      chk("rst_d_a_valid", d_o.a_valid, 0);
      chk("rst_h_d_valid", h_o.d_valid, 0);
      chk("rst_h_a_ready", h_o.a_ready, 1);
      chk("rst_d_d_ready", d_o.d_ready, 1);
      chk("rst_req_lvl", req_lvl, 0);
      chk("rst_rsp_lvl", rsp_lvl, 0);
      chk("rst_outst", outst, 0);
      chk("rst_err", err, 0);
      chk("rst_a_addr", d_o.a_address, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Pass-through instance: combinational handshakes and the in-flight limit
      h0_i.a_opcode = Get; h0_i.a_size = 2'd2; h0_i.a_source = 8'd3;
      h0_i.a_address = 32'h100; h0_i.a_mask = 4'hF;
      d0_i.d_opcode = AccessAckData; d0_i.d_data = 32'hDEADBEEF; d0_i.d_source = 8'd3;
      for (int i = 0; i < 14; i++) begin
         h0_i.a_valid = vecs[i].hav;
         d0_i.a_ready = vecs[i].dar;
         h0_i.d_ready = vecs[i].hdr;
         d0_i.d_valid = vecs[i].ddv;
         settle();
         chk($sformatf("v%0d_h_a_ready", i), h0_o.a_ready, vecs[i].exp_ar);
         chk($sformatf("v%0d_d_a_valid", i), d0_o.a_valid, vecs[i].exp_av);
         chk($sformatf("v%0d_h_d_valid", i), h0_o.d_valid, vecs[i].exp_dv);
         chk($sformatf("v%0d_d_d_ready", i), d0_o.d_ready, vecs[i].exp_dr);
         chk($sformatf("v%0d_outst", i), outst0, vecs[i].exp_out);
         if (vecs[i].exp_av) chk($sformatf("v%0d_a_addr", i), d0_o.a_address, 32'h100);
         if (vecs[i].exp_dv) chk($sformatf("v%0d_d_data", i), h0_o.d_data, 32'hDEADBEEF);
         tick();
      end
      h0_i = '0; d0_i = '0;
      settle();
      chk("p0_req_lvl", req_lvl0, 0);
      chk("p0_rsp_lvl", rsp_lvl0, 0);
      chk("p0_err", err0, 0);

      // Single Get round trip, one cycle each way
      d_i.a_ready = 1'b0;
      drive_a(Get, 32'h100, 32'h0, 8'd3);
      exp_q.push_back(32'h100);
      settle();
      chk("t1_h_a_ready", h_o.a_ready, 1);
      chk("t1_d_a_valid_same_cycle", d_o.a_valid, 0);
      tick();
      h_i.a_valid = 1'b0;
      settle();
      chk("t1_d_a_valid", d_o.a_valid, 1);
      chk("t1_a_opcode", d_o.a_opcode, Get);
      chk("t1_a_addr", d_o.a_address, 32'h100);
      chk("t1_a_size", d_o.a_size, 2);
      chk("t1_a_source", d_o.a_source, 3);
      chk("t1_req_lvl", req_lvl, 1);
      chk("t1_outst", outst, 1);
      d_i.a_ready = 1'b1;
      tick();
      d_i.a_ready = 1'b0;
      settle();
      chk("t1_a_drained", d_o.a_valid, 0);
      drive_d(AccessAckData, 32'hDEADBEEF, 8'd3);
      settle();
      chk("t1_d_d_ready", d_o.d_ready, 1);
      chk("t1_h_d_valid_same_cycle", h_o.d_valid, 0);
      tick();
      d_i.d_valid = 1'b0;
      settle();
      chk("t1_h_d_valid", h_o.d_valid, 1);
      chk("t1_d_data", h_o.d_data, 32'hDEADBEEF);
      chk("t1_d_source", h_o.d_source, 3);
      chk("t1_d_opcode", h_o.d_opcode, AccessAckData);
      chk("t1_rsp_lvl", rsp_lvl, 1);
      chk("t1_outst_before", outst, 1);
      h_i.d_ready = 1'b1;
      tick();
      h_i.d_ready = 1'b0;
      settle();
      chk("t1_outst_after", outst, 0);
      chk("t1_h_d_drained", h_o.d_valid, 0);

      // Device stalled: request FIFO fills, then drains in order
      d_i.a_ready = 1'b0;
      drive_a(PutFullData, 32'h200, 32'd1, 8'd1); exp_q.push_back(32'h200);
      settle(); chk("t2_rdy1", h_o.a_ready, 1);
      tick();
      drive_a(PutFullData, 32'h204, 32'd2, 8'd1); exp_q.push_back(32'h204);
      settle(); chk("t2_rdy2", h_o.a_ready, 1);
      tick();
      drive_a(PutFullData, 32'h208, 32'd3, 8'd1); exp_q.push_back(32'h208);
      settle();
      chk("t2_rdy3_full", h_o.a_ready, 0);
      chk("t2_req_lvl_full", req_lvl, 2);
      chk("t2_outst", outst, 2);
      tick(); settle();
      chk("t2_still_stalled", h_o.a_ready, 0);
      d_i.a_ready = 1'b1;
      settle();
      chk("t2_no_bypass", h_o.a_ready, 0);
      chk("t2_head1", d_o.a_data, 1);
      tick(); settle();
      chk("t2_req_lvl_after_pop", req_lvl, 1);
      chk("t2_rdy_after_pop", h_o.a_ready, 1);
      chk("t2_head2", d_o.a_data, 2);
      tick();
      h_i.a_valid = 1'b0;
      settle();
      chk("t2_head3", d_o.a_data, 3);
      chk("t2_req_lvl_pushpop", req_lvl, 1);
      chk("t2_outst3", outst, 3);
      tick(); settle();
      chk("t2_req_lvl_empty", req_lvl, 0);

      // In-flight limit with host holding off responses
      reset_dut();
      d_i.a_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         drive_a(PutFullData, 32'h300 + 32'(4 * k), 32'(k), 8'd2);
         exp_q.push_back(32'h300 + 32'(4 * k));
         settle();
         chk($sformatf("t3_rdy%0d", k), h_o.a_ready, 1);
         tick();
      end
      drive_a(PutFullData, 32'h310, 32'd4, 8'd2);
      settle();
      chk("t3_fifth_stall", h_o.a_ready, 0);
      chk("t3_outst_max", outst, 4);
      tick(); settle();
      chk("t3_still_stalled", h_o.a_ready, 0);
      chk("t3_req_lvl", req_lvl, 0);
      chk("t3_outst_hold", outst, 4);
      drive_d(AccessAck, 32'h0, 8'd2);
      tick();
      d_i.d_valid = 1'b0;
      h_i.d_ready = 1'b1;
      settle();
      chk("t3_h_d_valid", h_o.d_valid, 1);
      chk("t3_rdy_before_rsp", h_o.a_ready, 0);
      tick();
      h_i.d_ready = 1'b0;
      settle();
      chk("t3_rdy_after_rsp", h_o.a_ready, 1);
      chk("t3_outst_dec", outst, 3);
      exp_q.push_back(32'h310);
      tick();
      h_i.a_valid = 1'b0;
      settle();
      chk("t3_outst_refill", outst, 4);
      tick();

      // Simultaneous host accepts, and a full response FIFO that does not bypass
      reset_dut();
      d_i.a_ready = 1'b1;
      drive_a(Get, 32'h400, 32'h0, 8'd4); exp_q.push_back(32'h400);
      tick();
      drive_a(Get, 32'h404, 32'h0, 8'd4); exp_q.push_back(32'h404);
      tick();
      h_i.a_valid = 1'b0;
      drive_d(AccessAckData, 32'hA0, 8'd4);
      tick();
      drive_d(AccessAckData, 32'hA1, 8'd4);
      tick();
      drive_d(AccessAckData, 32'hA2, 8'd4);
      settle();
      chk("t4_d_ready_full", d_o.d_ready, 0);
      chk("t4_rsp_lvl_full", rsp_lvl, 2);
      chk("t4_outst2", outst, 2);
      drive_a(Get, 32'h408, 32'h0, 8'd4); exp_q.push_back(32'h408);
      h_i.d_ready = 1'b1;
      settle();
      chk("t4_h_a_ready", h_o.a_ready, 1);
      chk("t4_head_a0", h_o.d_data, 32'hA0);
      chk("t4_d_ready_full_pop", d_o.d_ready, 0);
      tick();
      h_i.a_valid = 1'b0;
      h_i.d_ready = 1'b0;
      settle();
      chk("t4_outst_both", outst, 2);
      chk("t4_rsp_lvl_pop", rsp_lvl, 1);
      chk("t4_head_a1", h_o.d_data, 32'hA1);
      chk("t4_d_ready_free", d_o.d_ready, 1);
      tick();
      d_i.d_valid = 1'b0;
      settle();
      chk("t4_rsp_lvl_refill", rsp_lvl, 2);
      chk("t4_outst_idle", outst, 2);
      h_i.d_ready = 1'b1;
      tick(); settle();
      chk("t4_head_a2", h_o.d_data, 32'hA2);
      chk("t4_outst1", outst, 1);
      tick();
      h_i.d_ready = 1'b0;
      settle();
      chk("t4_outst0", outst, 0);
      chk("t4_rsp_lvl0", rsp_lvl, 0);

      // Spurious response, then reset with buffered requests
      drive_d(AccessAck, 32'h55, 8'd7);
      h_i.d_ready = 1'b1;
      tick();
      d_i.d_valid = 1'b0;
      settle();
      chk("t6_err_before", err, 0);
      tick();
      h_i.d_ready = 1'b0;
      settle();
      chk("t6_err_set", err, 1);
      chk("t6_outst_zero", outst, 0);
      tick(); settle();
      chk("t6_err_sticky", err, 1);
      d_i.a_ready = 1'b0;
      drive_a(PutFullData, 32'h600, 32'd6, 8'd6);
      tick();
      drive_a(PutFullData, 32'h604, 32'd7, 8'd6);
      tick();
      h_i.a_valid = 1'b0;
      settle();
      chk("t6_req_lvl_buf", req_lvl, 2);
      chk("t6_outst_buf", outst, 2);
      rst_n = 1'b0;
      settle();
      chk("t6_rst_d_a_valid", d_o.a_valid, 0);
      chk("t6_rst_h_d_valid", h_o.d_valid, 0);
      chk("t6_rst_req_lvl", req_lvl, 0);
      chk("t6_rst_rsp_lvl", rsp_lvl, 0);
      chk("t6_rst_outst", outst, 0);
      chk("t6_rst_err", err, 0);
      chk("t6_rst_a_addr", d_o.a_address, 0);
      chk("t6_rst_a_data", d_o.a_data, 0);
      chk("t6_rst_h_a_ready", h_o.a_ready, 1);
      d_i.a_ready = 1'b1;
      tick();
      rst_n = 1'b1;
      tick(); settle();
      chk("t6_discarded", d_o.a_valid, 0);
      tick();

      // Device-side A order across all buffered-instance traffic
      chk("a_order_count", obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         chk($sformatf("a_order_%0d", i), obs_q[i], exp_q[i]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tlul_fifo_sync.md
Name: tlul_fifo_sync

Overview:
Parametrised TileLink-UL channel buffer placed between one TL-UL host and one TL-UL device, e.g. between the AHB-to-TL bridge and the device crossbar.
- Independent, configurable-depth FIFOs on the A (request) and D (response) channels; depth 0 gives combinational pass-through.
- Enforces a configurable limit on in-flight transactions.
- Reports occupancy and a sticky error on spurious responses.
- All channel ports use the tl_m2s_t / tl_s2m_t structs from TileLinkUL_pkg.

Parameters:
ReqDepth, 2, A-channel FIFO entries (0 = pass-through).
RspDepth, 2, D-channel FIFO entries (0 = pass-through).
MaxOutstanding, 4, maximum accepted-but-unanswered host requests (>=1).

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  asynchronous active-low reset
tl_h_i  in  tl_m2s_t  host-side request/d_ready
tl_h_o  out  tl_s2m_t  host-side response/a_ready
tl_d_o  out  tl_m2s_t  device-side request/d_ready
tl_d_i  in  tl_s2m_t  device-side response/a_ready
req_level_o  out  $clog2(ReqDepth+1)  A FIFO occupancy (width 1 when ReqDepth=0, reads 0)
rsp_level_o  out  $clog2(RspDepth+1)  D FIFO occupancy (width 1 when RspDepth=0, reads 0)
outstanding_o  out  $clog2(MaxOutstanding+1)  in-flight count
err_o  out  1  sticky spurious-response flag

Behaviour:
- Accept definitions:
  - host A accept = tl_h_i.a_valid && tl_h_o.a_ready
  - host D accept = tl_h_o.d_valid && tl_h_i.d_ready
  - device-side accepts are defined likewise on tl_d_o / tl_d_i.
- FIFO payloads:
  - A FIFO stores every tl_m2s_t field except a_valid and d_ready.
  - D FIFO stores every tl_s2m_t field except d_valid and a_ready.
  - Fields pass unmodified; order is strictly preserved.
- FIFOs are first-word-fall-through:
  - output valid = not empty; head payload is driven directly.
  - Minimum latency with depth>0 is 1 cycle from accept to valid on the far side.
- Push is allowed only when not full. No full-with-pop bypass, so host-side ready never depends combinationally on far-side ready.
- Push and pop in the same cycle: level unchanged; pointers wrap modulo depth.
- tl_h_o.a_ready = (ReqDepth>0 ? !a_full : tl_d_i.a_ready) && (outstanding_o < MaxOutstanding).
- tl_d_o.a_valid = (ReqDepth>0 ? !a_empty : tl_h_i.a_valid && outstanding_o < MaxOutstanding).
- D channel:
  - tl_d_o.d_ready = (RspDepth>0 ? !d_full : tl_h_i.d_ready).
  - tl_h_o.d_valid = (RspDepth>0 ? !d_empty : tl_d_i.d_valid).
- Depth 0: the channel is purely combinational with zero latency; the field mux selects the input struct.
- Outstanding counter:
  - +1 on host A accept, -1 on host D accept.
  - Both in the same cycle: unchanged.
  - Never exceeds MaxOutstanding, never wraps below 0.
- err_o:
  - Set on host D accept while outstanding_o==0 (counter held at 0).
  - Cleared only by reset.
- Reset (async assert, sync-to-clock deassert assumed upstream):
  - Pointers, levels, counter, err_o and FIFO storage go to 0.
  - Hence tl_h_o.d_valid=0, tl_d_o.a_valid=0, all payload fields 0.
  - tl_h_o.a_ready=1 when ReqDepth>0; tl_d_o.d_ready=1 when RspDepth>0.
- Reset mid-operation discards all buffered beats without emitting them.
- Unused d_sink/d_error/a_param pass through like any other field; no protocol checking beyond err_o.

Test Plan:
1. ReqDepth=RspDepth=2, Get addr 0x100 size 2 source 3 at cycle 0 -> tl_d_o.a_valid at cycle 1 with identical fields. Device AccessAckData 0xDEADBEEF source 3 -> tl_h_o.d_valid one cycle later with same data; outstanding_o 1->0.
2. tl_d_i.a_ready=0, host streams 3 PutFullData -> first two accepted, req_level_o=2, tl_h_o.a_ready=0. Release device -> third accepted; order 1,2,3 kept at device.
3. MaxOutstanding=4, device always ready, tl_h_i.d_ready=0 -> 4 requests accepted, 5th stalls with req_level_o=0. One host D accept -> a_ready=1 next cycle, outstanding_o 4->3.
4. outstanding_o=2, host A accept and host D accept same cycle -> outstanding_o stays 2. D FIFO full (2) with simultaneous pop -> tl_d_o.d_ready stays 0 that cycle.
5. ReqDepth=RspDepth=0 -> Get appears on tl_d_o in the same cycle; tl_h_o.a_ready mirrors tl_d_i.a_ready until outstanding_o=4, then 0.
6. Device sends D beat with outstanding_o=0 -> err_o=1, counter stays 0. rst_ni low mid-transfer with 2 buffered beats -> all valids, levels, counter, err_o 0 immediately.
